mem_io_responder: RTL

- Responder end of the CPU's byte-wide memory bus (mem_a / mem_dout / mem_wr in, mem_din out).
- Serves the 128 KB RAM and the memory-mapped I/O window (mem_a[17:16]==2'b11).
- Contains TX and RX byte FIFOs toward the UART, the cycle counter, and the program-stop flag.
- Generates io_buffer_full, which is fed back to the CPU's memory controller.

---
 rtl/mem_io_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: responder end of the CPU byte-wide memory bus serving RAM, UART FIFOs, cycle counter and stop flag
// Ports: clk_in / rst_in (asynchronous, active-low) clock and reset; rdy_in CPU pause (low freezes bus-side state);
//    mem_a / mem_dout / mem_wr CPU request, mem_din registered read data;
//    io_buffer_full TX near-full back-pressure to the CPU memory controller;
//    tx_valid / tx_data / tx_ready UART transmit stream; rx_valid / rx_data / rx_ready UART receive stream;
//    program_stop sticky program-stop indication.
// Option: define MEMIO_STOP_DRAIN_EN to hold program_stop until the stop byte has left the TX FIFO.
module mem_io_responder #(
   parameter int RAM_ADDR_WIDTH = 17,
   parameter int FIFO_WIDTH     = 3,
   parameter int FULL_MARGIN    = 2
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic [31:0] mem_a,
   input  logic [7:0]  mem_dout,
   input  logic        mem_wr,
   output logic [7:0]  mem_din,
   output logic        io_buffer_full,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        program_stop
);
   localparam int DEPTH = 2 ** FIFO_WIDTH;
   localparam logic [FIFO_WIDTH:0] L_DEPTH = (FIFO_WIDTH + 1)'(DEPTH);
   localparam logic [FIFO_WIDTH:0] L_MSB   = {1'b1, {FIFO_WIDTH{1'b0}}};

   logic [7:0]          r_ram    [0:(2 ** RAM_ADDR_WIDTH) - 1];
   logic [7:0]          r_tx_mem [0:DEPTH - 1];
   logic [7:0]          r_rx_mem [0:DEPTH - 1];
   logic [FIFO_WIDTH:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
   logic [31:0]         r_cnt;
   logic [31:8]         r_snap;
   logic [7:0]          r_din;
   logic                r_stop;
`ifdef MEMIO_STOP_DRAIN_EN
   logic                r_pend;
   logic [FIFO_WIDTH:0] r_stop_ptr;
`endif

   logic [17:0]         w_a;
   logic                w_rd, w_wr, w_stop_wr;
   logic                w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
   logic                w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
   logic [7:0]          w_tx_wdata, w_rx_head, w_rd_data;
   logic [FIFO_WIDTH:0] w_tx_free;
   logic                w_unused;

   always_comb begin
      w_a        = mem_a[17:0];
      w_rd       = rdy_in && !mem_wr;
      w_wr       = rdy_in && mem_wr;
      w_stop_wr  = w_wr && w_a == 18'h30004;
      w_tx_empty = r_tx_wp == r_tx_rp;
      w_tx_full  = (r_tx_wp ^ r_tx_rp) == L_MSB;
      w_rx_empty = r_rx_wp == r_rx_rp;
      w_rx_full  = (r_rx_wp ^ r_rx_rp) == L_MSB;
      w_tx_pop   = !w_tx_empty && tx_ready;
      // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
      w_tx_push  = (w_stop_wr || (w_wr && w_a == 18'h30000 && mem_dout != 8'h00)) && (!w_tx_full || w_tx_pop);
      w_tx_wdata = w_stop_wr ? 8'h00 : mem_dout;
      w_rx_push  = rx_valid && !w_rx_full;
      w_rx_pop   = w_rd && w_a == 18'h30000 && !w_rx_empty;
      w_rx_head  = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rp[FIFO_WIDTH-1:0]];
      w_tx_free  = L_DEPTH - (r_tx_wp - r_tx_rp);
      w_rd_data  = !mem_a[17]        ? r_ram[mem_a[RAM_ADDR_WIDTH-1:0]] :
                   w_a == 18'h30000 ? w_rx_head :
                   w_a == 18'h30004 ? r_cnt[7:0] :
                   w_a == 18'h30005 ? r_snap[15:8] :
                   w_a == 18'h30006 ? r_snap[23:16] :
                   w_a == 18'h30007 ? r_snap[31:24] : 8'h00;
      w_unused   = ^mem_a[31:18];
   end

   // storage arrays carry no reset; RAM contents survive reset
   always_ff @(posedge clk_in) begin
      if (w_wr && !mem_a[17]) r_ram[mem_a[RAM_ADDR_WIDTH-1:0]] <= mem_dout;
      if (w_tx_push) r_tx_mem[r_tx_wp[FIFO_WIDTH-1:0]] <= w_tx_wdata;
      if (w_rx_push) r_rx_mem[r_rx_wp[FIFO_WIDTH-1:0]] <= rx_data;
   end

   always_ff @(posedge clk_in or negedge rst_in)
      if (!rst_in) begin
         r_cnt      <= '0;
         r_snap     <= '0;
         r_din      <= '0;
         r_stop     <= 1'b0;
         r_tx_wp    <= '0;
         r_tx_rp    <= '0;
         r_rx_wp    <= '0;
         r_rx_rp    <= '0;
`ifdef MEMIO_STOP_DRAIN_EN
         r_pend     <= 1'b0;
         r_stop_ptr <= '0;
`endif
      end else begin
         r_cnt   <= r_cnt + 32'd1;
         r_tx_wp <= r_tx_wp + (FIFO_WIDTH + 1)'(w_tx_push);
         r_tx_rp <= r_tx_rp + (FIFO_WIDTH + 1)'(w_tx_pop);
         r_rx_wp <= r_rx_wp + (FIFO_WIDTH + 1)'(w_rx_push);
         r_rx_rp <= r_rx_rp + (FIFO_WIDTH + 1)'(w_rx_pop);
         if (w_rd) r_din <= w_rd_data;
         if (w_rd && w_a == 18'h30004) r_snap <= r_cnt[31:8];
`ifdef MEMIO_STOP_DRAIN_EN
         // the stop byte is identified by the slot it was written to; a fresh arm wins over a completing one
         if (r_pend && w_tx_pop && r_tx_rp == r_stop_ptr) begin
            r_stop <= 1'b1;
            r_pend <= 1'b0;
         end
         if (w_stop_wr && w_tx_push) begin
            r_pend     <= 1'b1;
            r_stop_ptr <= r_tx_wp;
         end
`else
         if (w_stop_wr) r_stop <= 1'b1;
`endif
      end

   assign mem_din        = r_din;
   assign io_buffer_full = 32'(w_tx_free) <= FULL_MARGIN;
   assign tx_valid       = !w_tx_empty;
   assign tx_data        = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rp[FIFO_WIDTH-1:0]];
   assign rx_ready       = !w_rx_full;
   assign program_stop   = r_stop;
endmodule
